// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
// Shared pipeline types.
//   opcode_t     : instruction opcode seen in the ID stage
//   halt_cause_t : reason the core was parked by halt_ctrl
//   halt_state_t : halt_ctrl sequencer states
// -----------------------------------------------------------------------------
package types_pkg;

   typedef enum logic [2:0] {
      ARITHM = 3'd0,
      ADDI   = 3'd1,
      LOAD   = 3'd2,
      STORE  = 3'd3,
      BRANCH = 3'd4,
      JUMP   = 3'd5,
      NOP    = 3'd6,
      HALT   = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      CAUSE_NONE    = 3'd0,
      CAUSE_HALT    = 3'd1,
      CAUSE_DIV0    = 3'd2,
      CAUSE_OVF     = 3'd3,
      CAUSE_ILLEGAL = 3'd4
   } halt_cause_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } halt_state_t;

endpackage

// File: rtl/halt_ctrl.sv
// -----------------------------------------------------------------------------
// halt_ctrl
// Halt sequencer sitting behind control_main. On a halt request it freezes
// the front end, lets the instructions already past ID retire for
// DRAIN_CYCLES cycles, then parks the core and holds the captured cause/PC.
//
// Ports
//   clk, rst_n     : clock, synchronous active-low reset
//   halt_sys       : halt request for the instruction in ID
//   opcode         : opcode of the instruction in ID
//   div0, overflow : exception flags used to classify the cause
//   pc_id          : PC of the instruction in ID
//   resume         : one-cycle request to leave HALTED (HALT cause only)
//   pc_en          : PC write enable
//   if_id_flush    : clear IF/ID to NOP
//   id_ex_bubble   : zero control fields entering ID/EX
//   halted         : core parked, pipeline empty (registered)
//   exc_valid      : a cause has been captured
//   exc_cause      : captured cause
//   exc_pc         : PC of the halting instruction
// -----------------------------------------------------------------------------
module halt_ctrl
   import types_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned PC_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             halt_sys,
   input  opcode_t          opcode,
   input  logic             div0,
   input  logic             overflow,
   input  logic [PC_W-1:0]  pc_id,
   input  logic             resume,
   output logic             pc_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             halted,
   output logic             exc_valid,
   output halt_cause_t      exc_cause,
   output logic [PC_W-1:0]  exc_pc
);

   // Counter preload: one DRAIN cycle is spent per count down to zero,
   // so DRAIN_CYCLES cycles need a start value of DRAIN_CYCLES-1.
   localparam logic [3:0] DRAIN_LOAD =
      (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

   // Fixed priority: arithmetic faults outrank an explicit HALT opcode;
   // anything else that control_main halts on is treated as illegal.
   function automatic halt_cause_t classify_cause(
      input logic    f_div0,
      input logic    f_ovf,
      input opcode_t f_op
   );
      if (f_div0)
         return CAUSE_DIV0;
      else if (f_ovf)
         return CAUSE_OVF;
      else if (f_op == HALT)
         return CAUSE_HALT;
      else
         return CAUSE_ILLEGAL;
   endfunction

   halt_state_t       state_q,     state_d;
   logic [3:0]        counter_q,   counter_d;
   logic              halted_q,    halted_d;
   logic              exc_valid_q, exc_valid_d;
   halt_cause_t       exc_cause_q, exc_cause_d;
   logic [PC_W-1:0]   exc_pc_q,    exc_pc_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RUN;
         counter_q   <= 4'd0;
         halted_q    <= 1'b0;
         exc_valid_q <= 1'b0;
         exc_cause_q <= CAUSE_NONE;
         exc_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         halted_q    <= halted_d;
         exc_valid_q <= exc_valid_d;
         exc_cause_q <= exc_cause_d;
         exc_pc_q    <= exc_pc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      counter_d    = counter_q;
      exc_valid_d  = exc_valid_q;
      exc_cause_d  = exc_cause_q;
      exc_pc_d     = exc_pc_q;
      // Frozen front end unless explicitly running with no request.
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;

      unique case (state_q)
         RUN: begin
            // A halt request takes precedence over a coincident resume.
            if (halt_sys) begin
               exc_valid_d = 1'b1;
               exc_cause_d = classify_cause(div0, overflow, opcode);
               exc_pc_d    = pc_id;
               if (DRAIN_CYCLES == 0) begin
                  state_d = HALTED;
               end else begin
                  state_d   = DRAIN;
                  counter_d = DRAIN_LOAD;
               end
            end else begin
               pc_en        = 1'b1;
               if_id_flush  = 1'b0;
               id_ex_bubble = 1'b0;
            end
         end

         DRAIN: begin
            // Further requests and resume are ignored; first capture sticks.
            if (counter_q == 4'd0)
               state_d = HALTED;
            else
               counter_d = counter_q - 4'd1;
         end

         HALTED: begin
            // Only a software HALT is resumable; faults need a reset.
            // exc_pc is kept so the PC mux can still see where we stopped.
            if (resume && (exc_cause_q == CAUSE_HALT)) begin
               state_d     = RUN;
               exc_valid_d = 1'b0;
               exc_cause_d = CAUSE_NONE;
            end
         end

         default: begin
            state_d = RUN;
         end
      endcase

      halted_d = (state_d == HALTED);
   end

   assign halted    = halted_q;
   assign exc_valid = exc_valid_q;
   assign exc_cause = exc_cause_q;
   assign exc_pc    = exc_pc_q;

endmodule

// File: tb/tb_halt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_halt_ctrl
// Two instances (DRAIN_CYCLES = 3 and 0) driven with identical stimulus and
// checked every cycle against a cycle-counting reference model.
// -----------------------------------------------------------------------------
module tb_halt_ctrl;
   import types_pkg::*;

   localparam int PC_W = 16;

   logic             clk;
   logic             rst_n;
   logic             halt_sys;
   opcode_t          opcode;
   logic             div0;
   logic             overflow;
   logic [PC_W-1:0]  pc_id;
   logic             resume;

   logic             pc_en_w        [2];
   logic             if_id_flush_w  [2];
   logic             id_ex_bubble_w [2];
   logic             halted_w       [2];
   logic             exc_valid_w    [2];
   halt_cause_t      exc_cause_w    [2];
   logic [PC_W-1:0]  exc_pc_w       [2];

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: "in halt" since a recorded edge; halted is simply
   // "at least D+1 edges have passed since the halt edge".
   int               drain_len [2] = '{3, 0};
   bit               m_in_halt [2];
   int               m_start   [2];
   halt_cause_t      m_cause   [2];
   logic [PC_W-1:0]  m_pc      [2];
   bit               m_valid   [2];
   int               edge_cnt;

   halt_ctrl #(.DRAIN_CYCLES(3), .PC_W(PC_W)) dut_d3 (
      .clk(clk), .rst_n(rst_n), .halt_sys(halt_sys), .opcode(opcode),
      .div0(div0), .overflow(overflow), .pc_id(pc_id), .resume(resume),
      .pc_en(pc_en_w[0]), .if_id_flush(if_id_flush_w[0]),
      .id_ex_bubble(id_ex_bubble_w[0]), .halted(halted_w[0]),
      .exc_valid(exc_valid_w[0]), .exc_cause(exc_cause_w[0]),
      .exc_pc(exc_pc_w[0])
   );

   halt_ctrl #(.DRAIN_CYCLES(0), .PC_W(PC_W)) dut_d0 (
      .clk(clk), .rst_n(rst_n), .halt_sys(halt_sys), .opcode(opcode),
      .div0(div0), .overflow(overflow), .pc_id(pc_id), .resume(resume),
      .pc_en(pc_en_w[1]), .if_id_flush(if_id_flush_w[1]),
      .id_ex_bubble(id_ex_bubble_w[1]), .halted(halted_w[1]),
      .exc_valid(exc_valid_w[1]), .exc_cause(exc_cause_w[1]),
      .exc_pc(exc_pc_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic halt_cause_t ref_cause(input logic d, input logic o,
                                              input opcode_t op);
      if (d)          return CAUSE_DIV0;
      if (o)          return CAUSE_OVF;
      if (op == HALT) return CAUSE_HALT;
      return CAUSE_ILLEGAL;
   endfunction

   function automatic bit ref_halted(input int i);
      return m_in_halt[i] && ((edge_cnt - m_start[i]) >= drain_len[i] + 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_in_halt[i] = 0;
         m_start[i]   = 0;
         m_cause[i]   = CAUSE_NONE;
         m_pc[i]      = '0;
         m_valid[i]   = 0;
      end
   endtask

   task automatic check_all(input string ctx);
      bit run_free;
      for (int i = 0; i < 2; i++) begin
         run_free = !m_in_halt[i] && !halt_sys;
         check($sformatf("%s[d%0d].pc_en", ctx, drain_len[i]), 32'(pc_en_w[i]), 32'(run_free));
         check($sformatf("%s[d%0d].if_id_flush", ctx, drain_len[i]), 32'(if_id_flush_w[i]), 32'(!run_free));
         check($sformatf("%s[d%0d].id_ex_bubble", ctx, drain_len[i]), 32'(id_ex_bubble_w[i]), 32'(!run_free));
         check($sformatf("%s[d%0d].halted", ctx, drain_len[i]), 32'(halted_w[i]), 32'(ref_halted(i)));
         check($sformatf("%s[d%0d].exc_valid", ctx, drain_len[i]), 32'(exc_valid_w[i]), 32'(m_valid[i]));
         check($sformatf("%s[d%0d].exc_cause", ctx, drain_len[i]), 32'(exc_cause_w[i]), 32'(m_cause[i]));
         check($sformatf("%s[d%0d].exc_pc", ctx, drain_len[i]), 32'(exc_pc_w[i]), 32'(m_pc[i]));
      end
   endtask

   // One clock cycle: drive at negedge, check, take the edge, update model.
   task automatic step(input string ctx, input logic r_n, input logic hs,
                       input opcode_t op, input logic d0, input logic ov,
                       input logic [PC_W-1:0] pc, input logic rs,
                       input bit glitch);
      rst_n = r_n; halt_sys = hs; opcode = op; div0 = d0; overflow = ov;
      pc_id = pc; resume = rs;
      if (glitch) begin
         // Reset pulse entirely between edges must have no effect.
         #1 rst_n = 1'b0;
         #1 rst_n = 1'b1;
      end
      #1;
      check_all(ctx);
      $display("[TB] %s rst_n=%0b halt_sys=%0b op=%s div0=%0b ovf=%0b pc=%04h resume=%0b | d3: pc_en=%0b halted=%0b cause=%s | d0: pc_en=%0b halted=%0b cause=%s",
               ctx, r_n, hs, op.name(), d0, ov, pc, rs,
               pc_en_w[0], halted_w[0], exc_cause_w[0].name(),
               pc_en_w[1], halted_w[1], exc_cause_w[1].name());
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!r_n) begin
            m_in_halt[i] = 0;
            m_valid[i]   = 0;
            m_cause[i]   = CAUSE_NONE;
            m_pc[i]      = '0;
         end else if (!m_in_halt[i]) begin
            if (hs) begin
               m_in_halt[i] = 1;
               m_start[i]   = edge_cnt;
               m_valid[i]   = 1;
               m_pc[i]      = pc;
               m_cause[i]   = ref_cause(d0, ov, op);
            end
         end else if (ref_halted(i) && rs && m_cause[i] == CAUSE_HALT) begin
            m_in_halt[i] = 0;
            m_valid[i]   = 0;
            m_cause[i]   = CAUSE_NONE;
         end
      end
      edge_cnt++;
      @(negedge clk);
   endtask

   task automatic idle(input string ctx, input int n);
      for (int k = 0; k < n; k++)
         step(ctx, 1'b1, 1'b0, NOP, 1'b0, 1'b0, 16'h0000, 1'b0, 0);
   endtask

   initial begin
      rst_n = 1'b0; halt_sys = 1'b0; opcode = NOP; div0 = 1'b0;
      overflow = 1'b0; pc_id = '0; resume = 1'b0;
      edge_cnt = 0;
      model_reset();
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      edge_cnt++;

      // 1: idle after reset
      idle("idle", 10);

      // 2: HALT opcode, drain, park, resume
      step("halt_op", 1'b1, 1'b1, HALT, 1'b0, 1'b0, 16'h0042, 1'b0, 0);
      check("halt_op.exc_pc_const", 32'(exc_pc_w[0]), 32'h0042);
      check("halt_op.exc_cause_const", 32'(exc_cause_w[0]), 32'(CAUSE_HALT));
      step("drain_resume_ignored", 1'b1, 1'b0, NOP, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
      idle("drain", 2);
      check("halt_op.halted_after_4", 32'(halted_w[0]), 32'd1);
      step("resume", 1'b1, 1'b0, NOP, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
      check("resume.exc_pc_kept", 32'(exc_pc_w[0]), 32'h0042);
      idle("after_resume", 2);

      // 3: div0 beats overflow; fault is not resumable
      step("div0_ovf", 1'b1, 1'b1, HALT, 1'b1, 1'b1, 16'h0100, 1'b0, 0);
      check("div0_ovf.cause_const", 32'(exc_cause_w[0]), 32'(CAUSE_DIV0));
      idle("drain", 4);
      step("resume_fault", 1'b1, 1'b0, NOP, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
      check("resume_fault.still_halted", 32'(halted_w[0]), 32'd1);
      idle("parked", 2);
      step("reset", 1'b0, 1'b0, NOP, 1'b0, 1'b0, 16'h0000, 1'b0, 0);

      // 4: illegal, second request during DRAIN ignored
      step("illegal", 1'b1, 1'b1, ARITHM, 1'b0, 1'b0, 16'h0010, 1'b0, 0);
      step("second_req", 1'b1, 1'b1, HALT, 1'b0, 1'b1, 16'h0011, 1'b0, 0);
      check("second_req.pc_const", 32'(exc_pc_w[0]), 32'h0010);

      // 5: reset in the second DRAIN cycle, then a glitch between edges
      step("reset_mid_drain", 1'b0, 1'b0, NOP, 1'b0, 1'b0, 16'h0000, 1'b0, 0);
      check("reset_mid_drain.pc_en", 32'(pc_en_w[0]), 32'd1);
      step("glitch_halt", 1'b1, 1'b1, HALT, 1'b0, 1'b0, 16'h0077, 1'b0, 1);
      step("glitch_drain", 1'b1, 1'b0, NOP, 1'b0, 1'b0, 16'h0000, 1'b0, 1);
      idle("drain", 3);
      step("resume2", 1'b1, 1'b0, NOP, 1'b0, 1'b0, 16'h0000, 1'b1, 0);

      // 6: resume together with halt_sys in RUN -> halt taken
      step("halt_and_resume", 1'b1, 1'b1, HALT, 1'b0, 1'b0, 16'h0200, 1'b1, 0);
      check("halt_and_resume.d0_halted", 32'(halted_w[1]), 32'd1);
      idle("drain", 4);
      step("resume3", 1'b1, 1'b0, NOP, 1'b0, 1'b0, 16'h0000, 1'b1, 0);

      // Randomised traffic against the model
      for (int n = 0; n < 400; n++) begin
         step("rand",
              ($urandom_range(0, 39) != 0),
              ($urandom_range(0, 5) == 0),
              opcode_t'($urandom_range(0, 7)),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 4) == 0),
              PC_W'($urandom),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 9) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
